// File: rtl/tt_vpu_ovi_pkg.sv
// Shared types for the OVI protocol monitor: per-ID state encoding and error codes.
package tt_vpu_ovi_pkg;

    localparam int NUM_ERR = 10;
    localparam int ERR_W   = 4;

    typedef enum logic [1:0] {
        SB_IDLE   = 2'd0,
        SB_ISSUED = 2'd1,
        SB_SENIOR = 2'd2
    } sb_state_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_ISSUE_BUSY    = 4'd0,
        ERR_DISP_STATE    = 4'd1,
        ERR_SENIOR_KILL   = 4'd2,
        ERR_CMPL_STATE    = 4'd3,
        ERR_CMPL_COLLIDE  = 4'd4,
        ERR_NO_CREDIT     = 4'd5,
        ERR_CREDIT_OVF    = 4'd6,
        ERR_MEM_UNDERFLOW = 4'd7,
        ERR_MEM_OVF       = 4'd8,
        ERR_TIMEOUT       = 4'd9
    } ovi_err_e;

endpackage

// File: rtl/tt_vpu_ovi_sb_entry.sv
// One tracked scoreboard ID: lifecycle FSM, senior watchdog and per-entry protocol error flags.
module tt_vpu_ovi_sb_entry
    import tt_vpu_ovi_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic issue,
    input  logic senior,
    input  logic kill,
    input  logic cmpl,
    output logic active_next,
    output logic err_busy,
    output logic err_disp,
    output logic err_cmpl,
    output logic err_timeout
);

    // One spare count above TIMEOUT lets the counter park there so the timeout fires once.
    localparam int WD_W = $clog2(TIMEOUT + 2);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_PARK  = WD_W'(TIMEOUT + 1);

    sb_state_e       state, state_next;
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= SB_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_busy   = 1'b0;
        err_disp   = 1'b0;
        case (state)
            SB_IDLE: begin
                if (issue) begin
                    if (senior && !kill)      state_next = SB_SENIOR;
                    else if (kill && !senior) state_next = SB_IDLE;
                    else                      state_next = SB_ISSUED;
                end else begin
                    err_disp = senior || kill;
                end
            end
            SB_ISSUED: begin
                err_busy = issue;
                if (senior && !kill)      state_next = SB_SENIOR;
                else if (kill && !senior) state_next = SB_IDLE;
            end
            SB_SENIOR: begin
                err_busy = issue;
                err_disp = senior || kill;
                if (cmpl) state_next = SB_IDLE;
            end
            default: state_next = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || state != SB_SENIOR) wd_cnt <= '0;
        else if (wd_cnt != WD_PARK)         wd_cnt <= wd_cnt + 1'b1;
    end

    assign err_cmpl    = cmpl && (state != SB_SENIOR);
    assign err_timeout = (TIMEOUT != 0) && (state == SB_SENIOR) && (wd_cnt == WD_LIMIT);
    assign active_next = (state_next != SB_IDLE);

endmodule

// File: rtl/tt_vpu_ovi_monitor.sv
// Passive OVI protocol monitor: per-ID tracking, credit/memop accounting, registered sticky errors.
module tt_vpu_ovi_monitor
    import tt_vpu_ovi_pkg::*;
#(
    parameter int SB_ID_W       = 5,
    parameter int ISSUE_CREDITS = 4,
    parameter int MEM_CNT_W     = 6,
    parameter int TIMEOUT       = 4096
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               issue_valid,
    input  logic                               issue_credit,
    input  logic [SB_ID_W-1:0]                 issue_sb_id,
    input  logic                               dispatch_next_senior,
    input  logic                               dispatch_kill,
    input  logic [SB_ID_W-1:0]                 dispatch_sb_id,
    input  logic                               completed_valid,
    input  logic [SB_ID_W-1:0]                 completed_sb_id,
    input  logic                               memop_sync_start,
    input  logic                               memop_sync_end,
    output logic [NUM_ERR-1:0]                 err_sticky,
    output logic                               err_valid,
    output logic [ERR_W-1:0]                   err_code,
    output logic [SB_ID_W-1:0]                 err_sb_id,
    output logic [$clog2(ISSUE_CREDITS+1)-1:0] credits,
    output logic [SB_ID_W:0]                   outstanding,
    output logic [MEM_CNT_W-1:0]               pending_mem
);

    localparam int NUM_SB = 2 ** SB_ID_W;
    localparam int CR_W   = $clog2(ISSUE_CREDITS + 1);
    localparam int OUT_W  = SB_ID_W + 1;
    localparam logic [CR_W-1:0] CR_MAX = CR_W'(ISSUE_CREDITS);

    logic [NUM_SB-1:0]  active_next, busy_vec, disp_vec, cmpl_vec, to_vec;
    logic               dispatch_any;
    logic [NUM_ERR-1:0] err_now;
    logic [SB_ID_W-1:0] err_id [NUM_ERR];
    logic [SB_ID_W-1:0] to_id, sb_id_next;
    logic [ERR_W-1:0]   code_next;
    logic [OUT_W-1:0]   outstanding_next;
    logic               credit_ovf, no_credit, mem_under, mem_ovf;

    assign dispatch_any = dispatch_next_senior || dispatch_kill;

    for (genvar i = 0; i < NUM_SB; i++) begin : g_sb
        tt_vpu_ovi_sb_entry #(
            .TIMEOUT (TIMEOUT)
        ) u_entry (
            .clk         (clk),
            .reset_n     (reset_n),
            .issue       (issue_valid && issue_sb_id == SB_ID_W'(i)),
            .senior      (dispatch_next_senior && dispatch_sb_id == SB_ID_W'(i)),
            .kill        (dispatch_kill && dispatch_sb_id == SB_ID_W'(i)),
            .cmpl        (completed_valid && completed_sb_id == SB_ID_W'(i)),
            .active_next (active_next[i]),
            .err_busy    (busy_vec[i]),
            .err_disp    (disp_vec[i]),
            .err_cmpl    (cmpl_vec[i]),
            .err_timeout (to_vec[i])
        );
    end

    assign no_credit  = issue_valid && (credits == '0);
    assign credit_ovf = issue_credit && !issue_valid && (credits == CR_MAX);
    assign mem_under  = memop_sync_end && !memop_sync_start && (pending_mem == '0);
    assign mem_ovf    = memop_sync_start && !memop_sync_end && (pending_mem == '1);

    always_comb begin
        to_id = '0;
        for (int unsigned i = NUM_SB; i > 0; i--) begin
            if (to_vec[i-1]) to_id = SB_ID_W'(i - 1);
        end
    end

    always_comb begin
        outstanding_next = '0;
        for (int unsigned i = 0; i < NUM_SB; i++) begin
            outstanding_next = outstanding_next + OUT_W'(active_next[i]);
        end
    end

    always_comb begin
        err_now[ERR_ISSUE_BUSY]    = |busy_vec;
        err_now[ERR_DISP_STATE]    = |disp_vec;
        err_now[ERR_SENIOR_KILL]   = dispatch_next_senior && dispatch_kill;
        err_now[ERR_CMPL_STATE]    = |cmpl_vec;
        err_now[ERR_CMPL_COLLIDE]  = completed_valid &&
                                     ((issue_valid && issue_sb_id == completed_sb_id) ||
                                      (dispatch_any && dispatch_sb_id == completed_sb_id));
        err_now[ERR_NO_CREDIT]     = no_credit;
        err_now[ERR_CREDIT_OVF]    = credit_ovf;
        err_now[ERR_MEM_UNDERFLOW] = mem_under;
        err_now[ERR_MEM_OVF]       = mem_ovf;
        err_now[ERR_TIMEOUT]       = |to_vec;

        err_id[ERR_ISSUE_BUSY]    = issue_sb_id;
        err_id[ERR_DISP_STATE]    = dispatch_sb_id;
        err_id[ERR_SENIOR_KILL]   = dispatch_sb_id;
        err_id[ERR_CMPL_STATE]    = completed_sb_id;
        err_id[ERR_CMPL_COLLIDE]  = completed_sb_id;
        err_id[ERR_NO_CREDIT]     = issue_sb_id;
        err_id[ERR_CREDIT_OVF]    = '0;
        err_id[ERR_MEM_UNDERFLOW] = '0;
        err_id[ERR_MEM_OVF]       = '0;
        err_id[ERR_TIMEOUT]       = to_id;

        code_next  = '0;
        sb_id_next = '0;
        for (int unsigned i = NUM_ERR; i > 0; i--) begin
            if (err_now[i-1]) begin
                code_next  = ERR_W'(i - 1);
                sb_id_next = err_id[i-1];
            end
        end
    end

    // Counters saturate: an overflowing/underflowing update is flagged and dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            credits     <= '0;
            pending_mem <= '0;
            outstanding <= '0;
            err_sticky  <= '0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            err_sb_id   <= '0;
        end else begin
            if (issue_credit && !issue_valid && credits != CR_MAX) credits <= credits + 1'b1;
            else if (issue_valid && !issue_credit && credits != '0) credits <= credits - 1'b1;

            if (memop_sync_start && !memop_sync_end && pending_mem != '1) pending_mem <= pending_mem + 1'b1;
            else if (memop_sync_end && !memop_sync_start && pending_mem != '0) pending_mem <= pending_mem - 1'b1;

            outstanding <= outstanding_next;
            err_sticky  <= err_sticky | err_now;
            err_valid   <= |err_now;
            if (|err_now) begin
                err_code  <= code_next;
                err_sb_id <= sb_id_next;
            end
        end
    end

endmodule

// File: doc/tt_vpu_ovi_monitor.md
# tt_vpu_ovi_monitor

Synthesizable, parametrised Open Vector Interface protocol monitor for the Ocelot VPU. It replaces the fixed 32-entry, assertion-only checks with per-scoreboard-ID state tracking, issue-credit accounting, memop-sync depth tracking and a completion watchdog. Violations are reported on registered, sticky error outputs usable in silicon debug, FPGA and formal. It sits beside `tt_vpu_ovi`, is purely observational, and snoops the OVI issue, dispatch, completed and memop buses.

## Interface
Parameters:
- `SB_ID_W`, 5: scoreboard ID width; `NUM_SB = 2**SB_ID_W` tracked entries.
- `ISSUE_CREDITS`, 4: credits the VPU owns at reset.
- `MEM_CNT_W`, 6: width of the pending-memop counter.
- `TIMEOUT`, 4096: maximum cycles from senior to completed; 0 disables the watchdog.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `issue_valid`, `issue_credit`  in  1  OVI issue handshake.
- `issue_sb_id`  in  SB_ID_W  ID of the issued instruction.
- `dispatch_next_senior`, `dispatch_kill`  in  1  dispatch events.
- `dispatch_sb_id`  in  SB_ID_W  ID for the dispatch event.
- `completed_valid`  in  1  completion strobe.
- `completed_sb_id`  in  SB_ID_W  ID for the completion.
- `memop_sync_start`, `memop_sync_end`  in  1  memop sync pulses.
- `err_sticky`  out  NUM_ERR  accumulated error bits.
- `err_valid`  out  1  one-cycle pulse on any new error.
- `err_code`  out  ERR_W  lowest-numbered error raised this cycle.
- `err_sb_id`  out  SB_ID_W  ID associated with `err_code`.
- `credits`  out  $clog2(ISSUE_CREDITS+1)  credits currently held by the core.
- `outstanding`  out  SB_ID_W+1  entries not in IDLE.
- `pending_mem`  out  MEM_CNT_W  open memop syncs.

## Operation
- **Per-ID FSM**, states IDLE, ISSUED, SENIOR:
  - IDLE→ISSUED on issue.
  - ISSUED→SENIOR on next_senior.
  - ISSUED→IDLE on kill.
  - SENIOR→IDLE on completed.
- **Same-cycle issue and dispatch on one ID:** issue+next_senior goes IDLE→SENIOR; issue+kill goes IDLE→IDLE. Neither is an error.
- **Credits:** count starts at 0 and is driven by the VPU. Update is `credits + issue_credit - issue_valid`; simultaneous credit and issue is net zero.
- **Memop count:** `pending_mem + start - end`; simultaneous start and end is net zero.
- **Error codes** (priority order; all raised bits are set in `err_sticky` the same cycle):
  - 0 `ERR_ISSUE_BUSY`: issue to an ID that is not IDLE.
  - 1 `ERR_DISP_STATE`: dispatch to an ID that is not ISSUED, excluding the same-cycle issue case.
  - 2 `ERR_SENIOR_KILL`: next_senior and kill both high.
  - 3 `ERR_CMPL_STATE`: completed on an ID that is not SENIOR.
  - 4 `ERR_CMPL_COLLIDE`: `completed_sb_id` equals a valid issue or dispatch ID in the same cycle.
  - 5 `ERR_NO_CREDIT`: issue while `credits == 0`.
  - 6 `ERR_CREDIT_OVF`: the credit update would exceed `ISSUE_CREDITS`.
  - 7 `ERR_MEM_UNDERFLOW`: end without start while `pending_mem == 0`.
  - 8 `ERR_MEM_OVF`: start without end while `pending_mem` is at its maximum.
  - 9 `ERR_TIMEOUT`: an entry has been in SENIOR for `TIMEOUT` cycles.
- **Error state updates:** on error the FSM still takes the legal transition where one exists, otherwise it holds state. Counters saturate at 0 and at their maximum.
- **Multiple simultaneous timeouts:** report the lowest ID.

## Timing
- All outputs are registered. Errors appear the cycle after the offending input.
- Reset values:
  - FSMs in IDLE.
  - `credits`, `outstanding`, `pending_mem` = 0.
  - `err_sticky`, `err_valid`, `err_code`, `err_sb_id` = 0.
- Reset asserted mid-operation clears all state in the next cycle; no errors are reported for lost entries.
- Watchdog: the counter clears on entry to SENIOR. `ERR_TIMEOUT` is raised once, on the cycle after the count reaches `TIMEOUT`, and is not re-raised until the entry leaves SENIOR.
- `err_sticky` clears only on reset.

## Structure
- Package `tt_vpu_ovi_pkg` contains:
  - the `sb_state_e` enum;
  - the `ovi_err_e` enum;
  - `NUM_ERR = 10`;
  - `ERR_W = 4`.
- Sub-module `tt_vpu_ovi_sb_entry`, generated `NUM_SB` times. It holds the FSM, the watchdog counter and the per-entry error flags (busy, disp, cmpl, timeout).
- The top level contains ID decode, credit and memop counters, priority encode, and the `outstanding` popcount.

## Test plan
- Reset; 4× `issue_credit`; issue ID 3; next_senior 3; completed 3 → no error, `outstanding` 1→0, `credits` 4→3.
- Issue ID 7 twice without dispatch → `err_valid`, `err_code = 0`, `err_sb_id = 7`, `err_sticky[0] = 1`.
- Issue ID 5 with same-cycle kill 5, then issue 5 again → no error; FSM of ID 5 is in ISSUED.
- `credits = 0` and `issue_valid` → `ERR_NO_CREDIT`; 5× `issue_credit` with `ISSUE_CREDITS = 4` → `ERR_CREDIT_OVF`, `credits` saturates at 4.
- `memop_sync_end` with `pending_mem = 0` → `ERR_MEM_UNDERFLOW`; start and end together → count unchanged, no error.
- `TIMEOUT = 16`; ID 2 senior with no completion → `ERR_TIMEOUT` raised exactly once, on cycle 17 after entry.
